// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core with req/ready instruction and data ports.
// Define MULTICYCLE_BRANCH_EN to execute beq/j; otherwise they trap as illegal.
module multicycle_datapath #(
  parameter int               WIDTH    = 32,
  parameter int               NREGS    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             imemReq,
  output logic [WIDTH-1:0] imemAddr,
  input  logic             imemReady,
  input  logic [31:0]      imemData,
  output logic             dmemReq,
  output logic             dmemWe,
  output logic [WIDTH-1:0] dmemAddr,
  output logic [WIDTH-1:0] dmemWdata,
  input  logic             dmemReady,
  input  logic [WIDTH-1:0] dmemRdata,
  output logic [WIDTH-1:0] pcQ,
  output logic [31:0]      instr,
  output logic             regWriteEnable,
  output logic [2:0]       state,
  output logic             illegal
);

  // state | meaning: FETCH instr+pc | DECODE read A/B | EXEC alu/branch | MEM data access | WB reg write
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam int RW = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t state_q, state_d, exec_next;

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] a_q, b_q, alu_out, mdr;
  logic [WIDTH-1:0] signimm, alu_result;
  logic [5:0]       opcode, funct;
  logic [RW-1:0]    rs, rt, rd, dest;
  logic             exec_legal;

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign rs      = instr[21 +: RW];
  assign rt      = instr[16 +: RW];
  assign rd      = instr[11 +: RW];
  assign dest    = (opcode == OP_RTYPE) ? rd : rt;
  assign signimm = WIDTH'(signed'(instr[15:0]));

`ifdef MULTICYCLE_BRANCH_EN
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  logic             pc_load;
  logic [WIDTH-1:0] pc_target, jump_target;

  // Narrow PCs keep only the low bits of the 28-bit jump region.
  if (WIDTH > 28) begin : g_jump_wide
    assign jump_target = {pcQ[WIDTH-1:28], instr[25:0], 2'b00};
  end else begin : g_jump_narrow
    assign jump_target = WIDTH'({instr[25:0], 2'b00});
  end
`endif

  always_comb begin
    alu_result = '0;
    exec_legal = 1'b0;
    exec_next  = FETCH;
`ifdef MULTICYCLE_BRANCH_EN
    pc_load    = 1'b0;
    pc_target  = pcQ;
`endif
    case (opcode)
      OP_RTYPE: begin
        exec_legal = 1'b1;
        exec_next  = WB;
        case (funct)
          FN_ADD:  alu_result = a_q + b_q;
          FN_SUB:  alu_result = a_q - b_q;
          FN_AND:  alu_result = a_q & b_q;
          FN_OR:   alu_result = a_q | b_q;
          FN_SLT:  alu_result = WIDTH'($signed(a_q) < $signed(b_q));
          default: exec_legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        exec_legal = 1'b1;
        exec_next  = WB;
        alu_result = a_q + signimm;
      end
      OP_LW, OP_SW: begin
        exec_legal = 1'b1;
        exec_next  = MEM;
        alu_result = a_q + signimm;
      end
`ifdef MULTICYCLE_BRANCH_EN
      OP_BEQ: begin
        exec_legal = 1'b1;
        pc_load    = (a_q == b_q);
        pc_target  = pcQ + (signimm << 2);
      end
      OP_J: begin
        exec_legal = 1'b1;
        pc_load    = 1'b1;
        pc_target  = jump_target;
      end
`endif
      default: exec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (imemReady) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = exec_legal ? exec_next : FETCH;
      MEM:     if (dmemReady) state_d = (opcode == OP_SW) ? FETCH : WB;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcQ     <= RESET_PC;
      instr   <= '0;
      illegal <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imemReady) begin
            instr <= imemData;
            pcQ   <= pcQ + WIDTH'(4);
          end
        end
        DECODE: begin
          a_q <= rf[rs];
          b_q <= rf[rt];
        end
        EXEC: begin
          if (exec_legal) begin
            alu_out <= alu_result;
`ifdef MULTICYCLE_BRANCH_EN
            if (pc_load) pcQ <= pc_target;
`endif
          end else begin
            illegal <= 1'b1;
          end
        end
        MEM: if (dmemReady && opcode == OP_LW) mdr <= dmemRdata;
        // Register 0 is never written, so it reads as zero without a read mux.
        WB: if (dest != '0) rf[dest] <= (opcode == OP_LW) ? mdr : alu_out;
        default: ;
      endcase
    end
  end

  assign imemReq        = (state_q == FETCH);
  assign imemAddr       = pcQ;
  assign dmemReq        = (state_q == MEM);
  assign dmemWe         = (state_q == MEM) && (opcode == OP_SW);
  assign dmemAddr       = alu_out;
  assign dmemWdata      = b_q;
  assign regWriteEnable = (state_q == WB);
  assign state          = state_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: runs a short program from 0x100 with
// instruction/data memory models and scripted ready stalls.
module tb_multicycle_datapath;

  logic        clock;
  logic        reset_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic        dmemReady;
  logic [31:0] dmemRdata;
  logic [31:0] pcQ;
  logic [31:0] instr;
  logic        regWriteEnable;
  logic [2:0]  state;
  logic        illegal;

  multicycle_datapath #(.WIDTH(32), .NREGS(32), .RESET_PC(32'h100)) dut (
    .clock(clock), .reset_n(reset_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
    .dmemReady(dmemReady), .dmemRdata(dmemRdata),
    .pcQ(pcQ), .instr(instr), .regWriteEnable(regWriteEnable), .state(state), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  logic [31:0] imem [256];
  logic [31:0] dmem [16];

  // Results of the most recent run_instr call.
  logic [31:0] r_start, r_next, r_addr, r_wdata;
  int          r_cycles, r_wen;
  logic        r_seen, r_we, r_stable;

  // Executes one instruction from FETCH back to FETCH, stalling the
  // fetch by istall cycles and each data access by dstall cycles.
  task automatic run_instr(input int istall, input int dstall);
    int   icnt, dcnt;
    logic fetched;
    icnt = 0; dcnt = 0; fetched = 1'b0;
    r_start = imemAddr; r_cycles = 0; r_wen = 0;
    r_seen = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0; r_stable = 1'b1;
    do begin
      imemReady = 1'b0;
      dmemReady = 1'b0;
      if (state == 3'd0) begin
        imemData = imem[imemAddr[9:2]];
        if (icnt >= istall) begin
          imemReady = 1'b1;
          fetched   = 1'b1;
        end
        icnt++;
      end
      if (dmemReq) begin
        if (!r_seen) begin
          r_seen = 1'b1; r_we = dmemWe; r_addr = dmemAddr; r_wdata = dmemWdata;
        end else if (dmemWe !== r_we || dmemAddr !== r_addr || dmemWdata !== r_wdata) begin
          r_stable = 1'b0;
        end
        if (dcnt >= dstall) begin
          dmemReady = 1'b1;
          dmemRdata = dmem[dmemAddr[5:2]];
          if (dmemWe) dmem[dmemAddr[5:2]] = dmemWdata;
        end
        dcnt++;
      end
      @(posedge clock);
      r_cycles++;
      @(negedge clock);
      if (regWriteEnable) r_wen++;
    end while (!(fetched && state == 3'd0) && r_cycles < 40);
    imemReady = 1'b0;
    dmemReady = 1'b0;
    r_next = imemAddr;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    imemReady = 1'b1; dmemReady = 1'b1;
    imemData = 32'hFFFF_FFFF; dmemRdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clock);
    total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state); else passed++;
    total++; if (pcQ !== 32'h100) $display("FAIL reset_pc: got %0h expected 100", pcQ); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %0h expected 0", instr); else passed++;
    total++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %0b expected 0", illegal); else passed++;
    total++; if (imemReq !== 1'b1) $display("FAIL reset_imemReq: got %0b expected 1", imemReq); else passed++;
    total++; if (dmemReq !== 1'b0) $display("FAIL reset_dmemReq: got %0b expected 0", dmemReq); else passed++;
    total++; if (dmemWe !== 1'b0) $display("FAIL reset_dmemWe: got %0b expected 0", dmemWe); else passed++;
    total++; if (regWriteEnable !== 1'b0) $display("FAIL reset_wen: got %0b expected 0", regWriteEnable); else passed++;
    imemReady = 1'b0; dmemReady = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    total++; if (imemAddr !== 32'h100) $display("FAIL first_fetch_addr: got %0h expected 100", imemAddr); else passed++;
  endtask

  task automatic test_alu_sequence();
    int cyc, wen;
    cyc = 0; wen = 0;
    run_instr(0, 0); cyc += r_cycles; wen += r_wen;
    total++; if (r_next !== 32'h104) $display("FAIL second_fetch_addr: got %0h expected 104", r_next); else passed++;
    run_instr(0, 0); cyc += r_cycles; wen += r_wen;
    run_instr(0, 0); cyc += r_cycles; wen += r_wen;
    total++; if (cyc !== 12) $display("FAIL alu3_cycles: got %0d expected 12", cyc); else passed++;
    total++; if (wen !== 3) $display("FAIL alu3_wen_pulses: got %0d expected 3", wen); else passed++;
    total++; if (r_next !== 32'h10C) $display("FAIL alu3_next_pc: got %0h expected 10c", r_next); else passed++;
  endtask

  task automatic test_mem_stall();
    int cyc;
    run_instr(0, 2); cyc = r_cycles;
    total++; if (r_seen !== 1'b1 || r_we !== 1'b1) $display("FAIL sw_access: seen %0b we %0b expected 1 1", r_seen, r_we); else passed++;
    total++; if (r_addr !== 32'd8) $display("FAIL sw_addr: got %0h expected 8", r_addr); else passed++;
    total++; if (r_wdata !== 32'd2) $display("FAIL sw_wdata: got %0h expected 2", r_wdata); else passed++;
    total++; if (r_stable !== 1'b1) $display("FAIL sw_hold_stable: got %0b expected 1", r_stable); else passed++;
    total++; if (r_cycles !== 6) $display("FAIL sw_stall_cycles: got %0d expected 6", r_cycles); else passed++;
    run_instr(0, 2); cyc += r_cycles;
    total++; if (r_we !== 1'b0 || r_addr !== 32'd8) $display("FAIL lw_access: we %0b addr %0h expected 0 8", r_we, r_addr); else passed++;
    total++; if (r_cycles !== 7) $display("FAIL lw_stall_cycles: got %0d expected 7", r_cycles); else passed++;
    total++; if (r_wen !== 1) $display("FAIL lw_wen: got %0d expected 1", r_wen); else passed++;
    total++; if (cyc !== 13) $display("FAIL swlw_total_cycles: got %0d expected 13", cyc); else passed++;
    run_instr(0, 0);
    total++; if (r_wdata !== 32'd2 || r_addr !== 32'd12) $display("FAIL lw_result_r4: got %0h@%0h expected 2@c", r_wdata, r_addr); else passed++;
    total++; if (r_cycles !== 4) $display("FAIL sw_nostall_cycles: got %0d expected 4", r_cycles); else passed++;
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'hFFFF_FFFD; exp_data[1] = 32'd1; exp_data[2] = 32'd7; exp_data[3] = 32'd5;
    run_instr(1, 0);
    total++; if (r_cycles !== 5) $display("FAIL fetch_stall_cycles: got %0d expected 5", r_cycles); else passed++;
    total++; if (r_next !== 32'h11C) $display("FAIL fetch_stall_next_pc: got %0h expected 11c", r_next); else passed++;
    for (int i = 0; i < 3; i++) begin
      run_instr(0, 0);
      total++; if (r_cycles !== 4 || r_wen !== 1) $display("FAIL rtype_%0d_timing: cycles %0d wen %0d expected 4 1", i, r_cycles, r_wen); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0);
      total++; if (r_wdata !== exp_data[i]) $display("FAIL alu_result_%0d: got %0h expected %0h", i, r_wdata, exp_data[i]); else passed++;
      total++; if (r_addr !== 32'(16 + 4 * i)) $display("FAIL alu_store_addr_%0d: got %0h expected %0h", i, r_addr, 16 + 4 * i); else passed++;
    end
  endtask

  task automatic test_reg_zero_and_slt();
    run_instr(0, 0);
    total++; if (r_wen !== 1) $display("FAIL r0_write_wen: got %0d expected 1", r_wen); else passed++;
    run_instr(0, 0);
    total++; if (r_wdata !== 32'd0) $display("FAIL r0_reads_zero: got %0h expected 0", r_wdata); else passed++;
    run_instr(0, 0);
    run_instr(0, 0);
    total++; if (r_wdata !== 32'd1) $display("FAIL slt_signed: got %0h expected 1", r_wdata); else passed++;
  endtask

  task automatic test_branch();
    total++; if (illegal !== 1'b0) $display("FAIL illegal_before_beq: got %0b expected 0", illegal); else passed++;
    run_instr(0, 0);
    total++; if (r_cycles !== 3 || r_wen !== 0) $display("FAIL beq_timing: cycles %0d wen %0d expected 3 0", r_cycles, r_wen); else passed++;
`ifdef MULTICYCLE_BRANCH_EN
    total++; if (r_next !== 32'h148) $display("FAIL beq_taken_pc: got %0h expected 148", r_next); else passed++;
    total++; if (illegal !== 1'b0) $display("FAIL beq_illegal: got %0b expected 0", illegal); else passed++;
    imem[32'h148 >> 2] = 32'h0000_0020;
    run_instr(0, 0);
    total++; if (r_next !== 32'h14C) $display("FAIL after_beq_pc: got %0h expected 14c", r_next); else passed++;
`else
    total++; if (r_next !== 32'h14C) $display("FAIL beq_disabled_pc: got %0h expected 14c", r_next); else passed++;
    total++; if (illegal !== 1'b1) $display("FAIL beq_disabled_illegal: got %0b expected 1", illegal); else passed++;
`endif
  endtask

  task automatic test_illegal();
    run_instr(0, 0);
    total++; if (illegal !== 1'b1) $display("FAIL op3f_illegal: got %0b expected 1", illegal); else passed++;
    total++; if (r_cycles !== 3 || r_wen !== 0) $display("FAIL op3f_timing: cycles %0d wen %0d expected 3 0", r_cycles, r_wen); else passed++;
    run_instr(0, 0);
    total++; if (r_cycles !== 3 || r_wen !== 0) $display("FAIL funct21_timing: cycles %0d wen %0d expected 3 0", r_cycles, r_wen); else passed++;
    run_instr(0, 0);
    total++; if (r_wdata !== 32'd2) $display("FAIL illegal_regs_unchanged: got %0h expected 2", r_wdata); else passed++;
    total++; if (illegal !== 1'b1) $display("FAIL illegal_sticky: got %0b expected 1", illegal); else passed++;
  endtask

  task automatic test_reset_mid_mem();
    int n;
    n = 0;
    imemData  = imem[imemAddr[9:2]];
    imemReady = 1'b1;
    dmemReady = 1'b0;
    while (state !== 3'd3 && n < 10) begin
      @(posedge clock);
      @(negedge clock);
      imemReady = 1'b0;
      n++;
    end
    total++; if (dmemReq !== 1'b1 || dmemAddr !== 32'd44) $display("FAIL mem_stall_entry: req %0b addr %0h expected 1 2c", dmemReq, dmemAddr); else passed++;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    total++; if (dmemReq !== 1'b0) $display("FAIL midreset_dmemReq: got %0b expected 0", dmemReq); else passed++;
    total++; if (illegal !== 1'b0) $display("FAIL midreset_illegal: got %0b expected 0", illegal); else passed++;
    total++; if (state !== 3'd0 || pcQ !== 32'h100) $display("FAIL midreset_state_pc: state %0d pc %0h expected 0 100", state, pcQ); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    run_instr(0, 0);
    total++; if (r_start !== 32'h100) $display("FAIL post_reset_fetch: got %0h expected 100", r_start); else passed++;
    total++; if (r_cycles !== 4 || r_wen !== 1) $display("FAIL post_reset_addi: cycles %0d wen %0d expected 4 1", r_cycles, r_wen); else passed++;
  endtask

  initial begin
    logic [31:0] prog [23];
    prog = '{32'h2001_0005, 32'h2002_FFFD, 32'h0022_1820, 32'hAC03_0008,
             32'h8C04_0008, 32'hAC04_000C, 32'h0081_2822, 32'h00A0_302A,
             32'h0023_3825, 32'h00E1_4024, 32'hAC05_0010, 32'hAC06_0014,
             32'hAC07_0018, 32'hAC08_001C, 32'h2000_0009, 32'hAC00_0020,
             32'h0041_482A, 32'hAC09_0024, 32'h1000_FFFF, 32'hFC00_0000,
             32'h0022_1821, 32'hAC03_0028, 32'hAC01_002C};
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 23; i++) imem[64 + i] = prog[i];
    reset_n = 1'b0; imemReady = 1'b0; dmemReady = 1'b0;
    imemData = 32'h0; dmemRdata = 32'h0;

    test_reset();
    test_alu_sequence();
    test_mem_stall();
    test_alu_ops();
    test_reg_zero_and_slt();
    test_branch();
    test_illegal();
    test_reset_mid_mem();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
